// File: rtl/edge_event_arbiter_pkg.sv
// Shared defaults and helpers for the edge event arbiter.
package edge_arb_pkg;

    localparam int N_CH_DEF = 4;
    localparam int TS_W_DEF = 16;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event bus: monitored lines in, one timestamped event out.
interface edge_event_arbiter_if
    import edge_arb_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int TS_W = TS_W_DEF
);

    localparam int IW = idx_w(N_CH);

    logic [N_CH-1:0] in;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_idx;
    logic [TS_W-1:0] out_ts;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] ovf;
    logic            clr_ovf;

    modport master (
        input  in, out_ready, clr_ovf,
        output out_valid, out_idx, out_ts, pending, ovf
    );

    modport slave (
        output in, out_ready, clr_ovf,
        input  out_valid, out_idx, out_ts, pending, ovf
    );

endinterface

// File: rtl/edge_event_arbiter_capture.sv
// One channel: edge detect, pending flag, timestamp latch, sticky overflow.
module edge_capture
    import edge_arb_pkg::*;
#(
    parameter bit INIT   = 1'b0,
    parameter bit ACTIVE = 1'b1,
    parameter int TS_W   = TS_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in,
    input  logic [TS_W-1:0] ts,
    input  logic            accept,
    input  logic            clr_ovf,
    output logic            pending,
    output logic [TS_W-1:0] ts_q,
    output logic            ovf
);

    logic last;
    logic hit;
    logic take;

    assign hit  = (last == !ACTIVE) && (in == ACTIVE);
    // an edge landing on the accept cycle re-arms instead of overflowing
    assign take = hit && (!pending || accept);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last    <= INIT;
            pending <= 1'b0;
            ts_q    <= '0;
            ovf     <= 1'b0;
        end else begin
            last <= in;
            if (hit)
                pending <= 1'b1;
            else if (accept)
                pending <= 1'b0;
            if (take)
                ts_q <= ts;
            if (hit && pending && !accept)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge capture, round-robin pick, one-deep output register.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter bit INIT   = 1'b0,
    parameter bit ACTIVE = 1'b1,
    parameter int TS_W   = TS_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    edge_event_arbiter_if.master bus
);

    localparam int IW = idx_w(N_CH);
    localparam logic [IW:0] NCH_W = (IW+1)'(N_CH);

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_q [N_CH];
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] ovf;
    logic [N_CH-1:0] acc_oh;
    logic [N_CH-1:0] cand;
    logic            accept;
    logic            free;
    logic            found;
    logic [IW:0]     pos;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   sel_nxt;
    logic [IW-1:0]   rr_ptr;
    logic            valid_q;
    logic [IW-1:0]   idx_q;
    logic [TS_W-1:0] ts_out_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_capture #(
            .INIT  (INIT),
            .ACTIVE(ACTIVE),
            .TS_W  (TS_W)
        ) u_cap (
            .clk    (clk),
            .rst_n  (rst_n),
            .in     (bus.in[i]),
            .ts     (ts),
            .accept (acc_oh[i]),
            .clr_ovf(bus.clr_ovf),
            .pending(pending[i]),
            .ts_q   (ts_q[i]),
            .ovf    (ovf[i])
        );
    end

    assign accept = valid_q && bus.out_ready;
    assign free   = !valid_q || accept;
    assign cand   = pending & ~acc_oh;

    always_comb begin
        acc_oh = '0;
        for (int i = 0; i < N_CH; i++)
            acc_oh[i] = accept && (idx_q == IW'(i));
    end

    // first candidate at or after rr_ptr, wrapping at N_CH
    always_comb begin
        found = 1'b0;
        sel   = '0;
        pos   = '0;
        for (int j = 0; j < N_CH; j++) begin
            pos = {1'b0, rr_ptr} + (IW+1)'(j);
            if (pos >= NCH_W)
                pos = pos - NCH_W;
            if (!found && cand[pos[IW-1:0]]) begin
                found = 1'b1;
                sel   = pos[IW-1:0];
            end
        end
    end

    assign sel_nxt = (sel == IW'(N_CH-1)) ? '0 : sel + IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts       <= '0;
            rr_ptr   <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            ts_out_q <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (free) begin
                valid_q <= found;
                if (found) begin
                    idx_q    <= sel;
                    ts_out_q <= ts_q[sel];
                    rr_ptr   <= sel_nxt;
                end
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_ts    = ts_out_q;
    assign bus.pending   = pending;
    assign bus.ovf       = ovf;

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of monitored input lines; legal range 2..16.
REQ-002 Parameter INIT, default 0: value loaded into each channel's last-sample register on reset.
REQ-003 Parameter ACTIVE, default 1: active level; an edge is a transition from !ACTIVE to ACTIVE.
REQ-004 Parameter TS_W, default 16: timestamp width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in  input  N_CH  monitored lines, synchronous to clk.
REQ-008 out_valid  output  1  an event is presented.
REQ-009 out_ready  input  1  consumer accepts the presented event.
REQ-010 out_idx  output  clog2(N_CH)  channel of the presented event.
REQ-011 out_ts  output  TS_W  timestamp captured when that event's edge was detected.
REQ-012 pending  output  N_CH  per-channel event-pending flags.
REQ-013 ovf  output  N_CH  sticky per-channel overflow flags.
REQ-014 clr_ovf  input  1  single-cycle pulse that clears all ovf bits.

Function
REQ-015 The detector shall keep last[i], which samples in[i] every cycle, and set edge[i] = (last[i]==!ACTIVE) && (in[i]==ACTIVE), combinationally from the current input.
REQ-016 A free-running counter ts shall increment every cycle and wrap modulo 2^TS_W.
REQ-017 On edge[i], the block shall set pending[i] and capture ts into ts_q[i] on the next rising edge.
REQ-018 An event is accepted in a cycle where out_valid && out_ready; pending[out_idx] shall then clear.
REQ-019 If edge[i] and the acceptance of channel i occur in the same cycle, pending[i] shall remain set and ts_q[i] shall take the new ts, with no overflow.
REQ-020 If edge[i] occurs while pending[i] is set and channel i is not being accepted, the edge shall be dropped, ts_q[i] kept, and ovf[i] set.
REQ-021 ovf bits shall hold until clr_ovf; if clr_ovf and a new overflow coincide, ovf shall be set.
REQ-022 The output register is free when !out_valid or when an acceptance occurs; when free, the block shall load from the candidates, defined as pending & ~(accepted channel one-hot).
REQ-023 Selection shall be round-robin: the first candidate at or after rr_ptr, modulo N_CH; after loading channel k, rr_ptr shall become (k+1) mod N_CH.
REQ-024 When the register is free and there are no candidates, out_valid shall deassert.
REQ-025 While out_valid && !out_ready, out_valid, out_idx and out_ts shall stay stable.
REQ-026 Latency: an edge detected in cycle t, with the register free and no competition, shall give out_valid at t+2.
REQ-027 Back-to-back acceptance shall sustain one event per cycle while candidates exist.

Reset
REQ-028 While rst_n==0 at a clock edge, the following shall reset: last to INIT, pending/ovf/rr_ptr/ts/ts_q to 0, out_valid to 0, out_idx to 0, out_ts to 0.
REQ-029 A reset mid-handshake shall discard all queued and presented events; no overflow is reported.
REQ-030 Edges shall be evaluated from the first cycle after reset is released.

Structure
REQ-031 Package edge_arb_pkg shall hold the TS_W default, the N_CH default, and a clog2-based index-width function.
REQ-032 Sub-module edge_capture shall hold one channel (last, pending, ts_q, ovf); the top level shall instantiate it N_CH times and add the arbiter and output register.

Verification
REQ-033 Single edge: N_CH=4, out_ready=1, in[2] rises at cycle 10 (ts=10) -> out_valid at cycle 12, out_idx=2, out_ts=10, pending[2] cleared after acceptance.
REQ-034 Simultaneous edges: in[0], in[1] and in[3] all rise in cycle 5, out_ready=1 -> events are presented in order idx 0, 1, 3 on consecutive cycles, all with out_ts=5.
REQ-035 Backpressure and overflow: out_ready=0, in[1] pulses twice -> first event held stable and ovf[1]=1; clr_ovf -> ovf=0.
REQ-036 Accept-and-edge collision: in[0] edge in the same cycle channel 0 is accepted -> pending[0] stays 1, ovf[0]=0, second event presented with the new ts.
REQ-037 Fairness: in[0] toggles continuously and in[3] has one edge, out_ready=1 -> channel 3 is granted within N_CH accepted events.
REQ-038 Reset and parameters: rst_n=0 while out_valid=1 -> out_valid=0 and pending=0 on the next cycle; with ACTIVE=0 and INIT=1, a falling edge is detected and a rising edge is not; with TS_W=4, ts wraps 15->0.
